// File: rtl/rom_lut_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port ROM among NUM_REQ lanes, 2-cycle read latency.
// Optional: define ROM_ARB_COALESCE_EN to serve every lane requesting the winner's address with one read.
module rom_lut_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rom_enable,
  output logic [ADDR_WIDTH-1:0]         rom_address,
  input  logic [DATA_WIDTH-1:0]         rom_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_WIDTH-1:0] lane_addr [NUM_REQ];
  logic [NUM_REQ-1:0]    grant_mask;
  logic                  found;
  logic                  grant;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [IDX_W-1:0]      idx_sel;
  int                    idx;

  logic [ID_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
  logic                  s1_valid_reg;
  logic [ID_WIDTH-1:0]   s1_id_reg;
  logic [NUM_REQ-1:0]    s1_mask_reg;
  logic [NUM_REQ-1:0]    rsp_valid_reg;
  logic [ID_WIDTH-1:0]   rsp_id_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef ROM_ARB_COALESCE_EN
      // Every lane asking for the winner's word rides on the same ROM read.
      assign grant_mask[gi] = grant & req_valid[gi] & (lane_addr[gi] == win_addr);
`else
      assign grant_mask[gi] = grant & (win_id == ID_WIDTH'(gi));
`endif
    end
  endgenerate

  // Rotating priority search starting at rr_ptr; reset also blanks the ROM port.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    win_addr = '0;
    idx      = 0;
    idx_sel  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_sel = IDX_W'(idx);
      if (!found && req_valid[idx_sel]) begin
        found    = 1'b1;
        win_id   = ID_WIDTH'(idx);
        win_addr = lane_addr[idx_sel];
      end
    end
    grant       = found & ~hold & ~reset;
    rr_ptr_next = rr_ptr_reg;
    if (grant) rr_ptr_next = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
  end

  assign req_ready   = grant_mask;
  assign rom_enable  = grant;
  assign rom_address = grant ? win_addr : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_id_reg    <= '0;
      s1_mask_reg  <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      s1_valid_reg <= grant;
      s1_id_reg    <= win_id;
      s1_mask_reg  <= grant_mask;
    end
  end

  // ROM data is valid the cycle after the read; id/data hold when no read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_reg <= '0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= s1_valid_reg ? s1_mask_reg : '0;
      if (s1_valid_reg) begin
        rsp_id_reg   <= s1_id_reg;
        rsp_data_reg <= rom_data;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_rom_lut_arbiter.sv
// Directed bench for rom_lut_arbiter with a behavioural synchronous ROM (word = {4'hA, addr, addr}).
module tb_rom_lut_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_addr = '0;
  logic [3:0]  req_ready;
  logic        rom_enable;
  logic [5:0]  rom_address;
  logic [15:0] rom_data = '0;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;

  int errors = 0;
  int checks = 0;

  rom_lut_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(6), .DATA_WIDTH(16), .ID_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rom_enable(rom_enable), .rom_address(rom_address), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [5:0] a);
    return {4'hA, a, a};
  endfunction

  always @(posedge clk) if (rom_enable) rom_data <= rom_word(rom_address);

  task automatic set_addrs(input logic [5:0] a0, input logic [5:0] a1,
                           input logic [5:0] a2, input logic [5:0] a3);
    req_addr = {a3, a2, a1, a0};
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1; req_valid = '0; hold = 1'b0; req_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; hold = 1'b0; req_valid = 4'hF;
    set_addrs(6'd5, 6'd9, 6'd17, 6'd33);
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rom_enable !== 1'b0) begin errors++; $display("FAIL reset_rom_enable: got %b expected 0", rom_enable); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    @(negedge clk);
    reset = 1'b0; #1;
    $display("reset release: ready=%b addr=%0d", req_ready, rom_address);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
    checks++; if (rom_address !== 6'd5) begin errors++; $display("FAIL reset_first_addr: got %0d expected 5", rom_address); end
    req_valid = '0;
  endtask

  task automatic test_round_robin;
    logic [5:0] a [4] = '{6'd5, 6'd9, 6'd17, 6'd33};
    int g, r;
    apply_reset();
    req_valid = 4'hF;
    set_addrs(6'd5, 6'd9, 6'd17, 6'd33);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      g = c % 4;
      $display("rr cyc %0d: ready=%b addr=%0d rsp_valid=%b id=%0d data=%h", c, req_ready, rom_address, rsp_valid, rsp_id, rsp_data);
      checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, 4'(1 << g)); end
      checks++; if (rom_address !== a[g]) begin errors++; $display("FAIL rr_addr c%0d: got %0d expected %0d", c, rom_address, a[g]); end
      if (c >= 2) begin
        r = (c - 2) % 4;
        checks++; if (rsp_valid !== 4'(1 << r)) begin errors++; $display("FAIL rr_rsp_valid c%0d: got %b expected %b", c, rsp_valid, 4'(1 << r)); end
        checks++; if (rsp_id !== 2'(r)) begin errors++; $display("FAIL rr_rsp_id c%0d: got %0d expected %0d", c, rsp_id, r); end
        checks++; if (rsp_data !== rom_word(a[r])) begin errors++; $display("FAIL rr_rsp_data c%0d: got %h expected %h", c, rsp_data, rom_word(a[r])); end
      end else begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_rsp_idle c%0d: got %b expected 0000", c, rsp_valid); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single_lane;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      req_valid = (c < 4) ? 4'b0100 : 4'b0000;
      set_addrs(6'd0, 6'd0, 6'(c), 6'd0);
      #1;
      $display("single cyc %0d: ready=%b addr=%0d rsp_valid=%b id=%0d data=%h", c, req_ready, rom_address, rsp_valid, rsp_id, rsp_data);
      if (c < 4) begin
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant c%0d: got %b expected 0100", c, req_ready); end
        checks++; if (rom_address !== 6'(c)) begin errors++; $display("FAIL single_addr c%0d: got %0d expected %0d", c, rom_address, c); end
      end else begin
        checks++; if (rom_enable !== 1'b0) begin errors++; $display("FAIL single_idle c%0d: got %b expected 0", c, rom_enable); end
      end
      if (c >= 2) begin
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid c%0d: got %b expected 0100", c, rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id c%0d: got %0d expected 2", c, rsp_id); end
        checks++; if (rsp_data !== rom_word(6'(c - 2))) begin errors++; $display("FAIL single_rsp_data c%0d: got %h expected %h", c, rsp_data, rom_word(6'(c - 2))); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_hold;
    logic [5:0] a [4] = '{6'd5, 6'd9, 6'd17, 6'd33};
    int exp_gnt [9] = '{0, 1, -1, -1, -1, 2, 3, -1, -1};
    int exp_rsp [9] = '{-1, -1, 0, 1, -1, -1, -1, 2, 3};
    int g, r;
    apply_reset();
    set_addrs(6'd5, 6'd9, 6'd17, 6'd33);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      hold = (c >= 2 && c <= 4);
      req_valid = (c <= 6) ? 4'hF : 4'h0;
      #1;
      g = exp_gnt[c];
      r = exp_rsp[c];
      $display("hold cyc %0d: hold=%b ready=%b en=%b rsp_valid=%b id=%0d data=%h", c, hold, req_ready, rom_enable, rsp_valid, rsp_id, rsp_data);
      if (g >= 0) begin
        checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL hold_grant c%0d: got %b expected %b", c, req_ready, 4'(1 << g)); end
        checks++; if (rom_address !== a[g]) begin errors++; $display("FAIL hold_addr c%0d: got %0d expected %0d", c, rom_address, a[g]); end
      end else begin
        checks++; if (rom_enable !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL hold_idle c%0d: got en=%b ready=%b expected en=0 ready=0000", c, rom_enable, req_ready); end
      end
      if (r >= 0) begin
        checks++; if (rsp_valid !== 4'(1 << r)) begin errors++; $display("FAIL hold_rsp_valid c%0d: got %b expected %b", c, rsp_valid, 4'(1 << r)); end
        checks++; if (rsp_data !== rom_word(a[r])) begin errors++; $display("FAIL hold_rsp_data c%0d: got %h expected %h", c, rsp_data, rom_word(a[r])); end
      end else begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL hold_rsp_idle c%0d: got %b expected 0000", c, rsp_valid); end
      end
      if (c == 4) begin
        checks++; if (rsp_data !== rom_word(6'd9)) begin errors++; $display("FAIL hold_data_kept: got %h expected %h", rsp_data, rom_word(6'd9)); end
      end
    end
    hold = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_reset_inflight;
    apply_reset();
    req_valid = 4'b0010;
    set_addrs(6'd0, 6'd7, 6'd0, 6'd0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL inflight_grant: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL inflight_during_reset: got %b expected 0000", rsp_valid); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      $display("inflight cyc %0d: rsp_valid=%b", c, rsp_valid);
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL inflight_dropped c%0d: got %b expected 0000", c, rsp_valid); end
    end
  endtask

  task automatic test_same_addr;
    apply_reset();
    set_addrs(6'd0, 6'd12, 6'd0, 6'd12);
    req_valid = 4'b1010;
    #1;
`ifdef ROM_ARB_COALESCE_EN
    checks++; if (req_ready !== 4'b1010) begin errors++; $display("FAIL same_grant0: got %b expected 1010", req_ready); end
    @(negedge clk); req_valid = 4'b0000; #1;
    checks++; if (rom_enable !== 1'b0) begin errors++; $display("FAIL same_idle1: got %b expected 0", rom_enable); end
    @(negedge clk); #1;
    $display("same cyc 2: rsp_valid=%b id=%0d data=%h", rsp_valid, rsp_id, rsp_data);
    checks++; if (rsp_valid !== 4'b1010) begin errors++; $display("FAIL same_rsp_valid: got %b expected 1010", rsp_valid); end
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL same_rsp_id: got %0d expected 1", rsp_id); end
    checks++; if (rsp_data !== rom_word(6'd12)) begin errors++; $display("FAIL same_rsp_data: got %h expected %h", rsp_data, rom_word(6'd12)); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL same_rsp_after: got %b expected 0000", rsp_valid); end
`else
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL same_grant0: got %b expected 0010", req_ready); end
    @(negedge clk); req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL same_grant1: got %b expected 1000", req_ready); end
    @(negedge clk); req_valid = 4'b0000; #1;
    $display("same cyc 2: rsp_valid=%b id=%0d data=%h", rsp_valid, rsp_id, rsp_data);
    checks++; if (rom_enable !== 1'b0) begin errors++; $display("FAIL same_idle2: got %b expected 0", rom_enable); end
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL same_rsp0_valid: got %b expected 0010", rsp_valid); end
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL same_rsp0_id: got %0d expected 1", rsp_id); end
    checks++; if (rsp_data !== rom_word(6'd12)) begin errors++; $display("FAIL same_rsp0_data: got %h expected %h", rsp_data, rom_word(6'd12)); end
    @(negedge clk); #1;
    $display("same cyc 3: rsp_valid=%b id=%0d data=%h", rsp_valid, rsp_id, rsp_data);
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL same_rsp1_valid: got %b expected 1000", rsp_valid); end
    checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL same_rsp1_id: got %0d expected 3", rsp_id); end
    checks++; if (rsp_data !== rom_word(6'd12)) begin errors++; $display("FAIL same_rsp1_data: got %h expected %h", rsp_data, rom_word(6'd12)); end
`endif
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_lane();
    test_hold();
    test_reset_inflight();
    test_same_addr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
